// File: rtl/fifo_sync_pkg.sv
// fifo_sync_pkg -- shared helpers for the single-clock FIFO.
//   cntWidth(depth) : width of count/threshold/watermark signals, able to hold 0..depth+1
//   ptrInc(ptr, d)  : pointer advance over 0..d-1, wrapping by compare so any depth works
//   fifoErr_t       : reserved encoding for a future error-flag output
package fifo_sync_pkg;

  typedef enum logic [1:0] {
    FIFO_ERR_NONE      = 2'd0,
    FIFO_ERR_OVERFLOW  = 2'd1,
    FIFO_ERR_UNDERFLOW = 2'd2
  } fifoErr_t;

  function automatic int cntWidth(input int depth);
    return $clog2(depth + 2);
  endfunction

  function automatic int unsigned ptrInc(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_sync_if.sv
// fifo_sync_if -- streaming write/read handshake bundle of fifo_sync.
//   i_wdata/i_wvalid/o_wready : producer side
//   o_rdata/o_rvalid/i_rready : consumer side
//   modport slave  : the FIFO
//   modport master : the producer/consumer environment
interface fifo_sync_if
  import fifo_sync_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] i_wdata;
  logic             i_wvalid;
  logic             o_wready;
  logic [WIDTH-1:0] o_rdata;
  logic             o_rvalid;
  logic             i_rready;

  modport slave  (input  i_wdata, i_wvalid, i_rready,
                  output o_wready, o_rdata, o_rvalid);
  modport master (output i_wdata, i_wvalid, i_rready,
                  input  o_wready, o_rdata, o_rvalid);
endinterface

// File: rtl/fifo_sync_outreg.sv
// fifo_sync_outreg -- single-entry registered output stage with valid/ready on both sides.
//   i_clk, i_rst (sync, active-low), i_en (clock-gate), i_clr (synchronous empty)
//   s_valid/s_data/s_ready : upstream (storage head)
//   m_valid/m_data/m_ready : downstream (consumer), driven from flops
// The stage accepts a new entry in the same cycle its current one is taken,
// so back-to-back transfers run at one per cycle.
module fifo_sync_outreg #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ready,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready
);
  logic             vld_p0;
  logic [WIDTH-1:0] data_p0;

  assign s_ready = !vld_p0 || m_ready;
  assign m_valid = vld_p0;
  assign m_data  = data_p0;

  // stage 0: output register
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      vld_p0 <= 1'b0;
    end else if (i_en) begin
      if (i_clr)        vld_p0 <= 1'b0;
      else if (s_ready) vld_p0 <= s_valid;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_en && !i_clr && s_valid && s_ready) data_p0 <= s_data;
  end

endmodule

// File: rtl/fifo_sync.sv
// fifo_sync -- single-clock FIFO, any DEPTH >= 2, with occupancy count,
// run-time almost-full/almost-empty thresholds, synchronous flush and a
// peak-occupancy watermark.
//   i_clk, i_rst (sync, active-low), i_cg (clock-gate), i_flush
//   bus (fifo_sync_if.slave) : write and read valid/ready handshakes, show-ahead read
//   i_afThresh/i_aeThresh -> o_almostFull/o_almostEmpty
//   o_count, o_maxCount, i_clearMax, o_wpushed, o_rpopped
// Optional: define FIFO_SYNC_OUTREG_EN to register o_rdata/o_rvalid/o_almostEmpty
// through fifo_sync_outreg; capacity then becomes DEPTH+1.
module fifo_sync
  import fifo_sync_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 8,
  parameter int FLOPS_NOT_MEM = 0,
  localparam int CNT_W        = cntWidth(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cg,
  input  logic             i_flush,
  fifo_sync_if.slave       bus,
  input  logic [CNT_W-1:0] i_afThresh,
  input  logic [CNT_W-1:0] i_aeThresh,
  output logic             o_almostFull,
  output logic             o_almostEmpty,
  output logic [CNT_W-1:0] o_count,
  output logic [CNT_W-1:0] o_maxCount,
  input  logic             i_clearMax,
  output logic             o_wpushed,
  output logic             o_rpopped
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] cnt, cnt_next;      // entries held in storage
  logic [CNT_W-1:0] occ, occ_next;      // entries visible to the user
  logic [CNT_W-1:0] max_q, max_next;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             active, s_wready, s_rvalid, push, s_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return PTR_W'(ptrInc(32'(p), 32'(DEPTH)));
  endfunction

  assign active   = i_cg && !i_flush;
  assign s_wready = active && (cnt != CNT_W'(DEPTH));
  assign s_rvalid = active && (cnt != '0);
  assign push     = s_wready && bus.i_wvalid;

  assign bus.o_wready = s_wready;
  assign o_wpushed    = push;
  assign o_count      = occ;
  assign o_maxCount   = max_q;
  assign o_almostFull = (occ >= i_afThresh);

  always_comb begin
    cnt_next = cnt;
    if (i_flush)              cnt_next = '0;
    else if (push && !s_pop)  cnt_next = cnt + CNT_W'(1);
    else if (!push && s_pop)  cnt_next = cnt - CNT_W'(1);
  end

  // Clear-max together with flush naturally loads 0 because occ_next is 0.
  always_comb begin
    max_next = max_q;
    if (i_clearMax)           max_next = occ_next;
    else if (occ_next > max_q) max_next = occ_next;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      max_q <= '0;
    end else if (i_cg) begin
      cnt   <= cnt_next;
      max_q <= max_next;
      if (i_flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push)  wptr <= next_ptr(wptr);
        if (s_pop) rptr <= next_ptr(rptr);
      end
    end
  end

  // Storage carries no reset; flush leaves contents in place.
  generate
    if (FLOPS_NOT_MEM != 0) begin : g_flops
      for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        always_ff @(posedge i_clk) begin
          if (push && (wptr == PTR_W'(i))) mem[i] <= bus.i_wdata;
        end
      end
    end else begin : g_ram
      always_ff @(posedge i_clk) begin
        if (push) mem[wptr] <= bus.i_wdata;
      end
    end
  endgenerate

`ifdef FIFO_SYNC_OUTREG_EN
  logic stg_ready, ae_q;

  fifo_sync_outreg #(.WIDTH(WIDTH)) u_outreg (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (i_cg),
    .i_clr   (i_flush),
    .s_valid (s_rvalid),
    .s_data  (mem[rptr]),
    .s_ready (stg_ready),
    .m_valid (bus.o_rvalid),
    .m_data  (bus.o_rdata),
    .m_ready (bus.i_rready)
  );

  assign s_pop         = s_rvalid && stg_ready;
  assign o_rpopped     = active && bus.o_rvalid && bus.i_rready;
  assign o_almostEmpty = ae_q;

  always_comb begin
    occ_next = occ;
    if (i_flush)                  occ_next = '0;
    else if (push && !o_rpopped)  occ_next = occ + CNT_W'(1);
    else if (!push && o_rpopped)  occ_next = occ - CNT_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      occ  <= '0;
      ae_q <= 1'b1;
    end else if (i_cg) begin
      occ  <= occ_next;
      ae_q <= (occ_next <= i_aeThresh);
    end
  end
`else
  assign s_pop         = s_rvalid && bus.i_rready;
  assign o_rpopped     = s_pop;
  assign bus.o_rvalid  = s_rvalid;
  assign bus.o_rdata   = mem[rptr];
  assign occ           = cnt;
  assign occ_next      = cnt_next;
  assign o_almostEmpty = (occ <= i_aeThresh);
`endif

endmodule

// File: tb/tb_fifo_sync.sv
module tb_fifo_sync;
  import fifo_sync_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 5;
  localparam int CNT_W = cntWidth(DEPTH);

  logic clk = 1'b0;
  logic rst, cg, flush, clr;
  logic [CNT_W-1:0] af, ae;
  logic af_o, ae_o, wpushed, rpopped;
  logic [CNT_W-1:0] cnt_o, max_o;

  fifo_sync_if #(.WIDTH(WIDTH)) bus ();

  fifo_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FLOPS_NOT_MEM(0)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cg         (cg),
    .i_flush      (flush),
    .bus          (bus),
    .i_afThresh   (af),
    .i_aeThresh   (ae),
    .o_almostFull (af_o),
    .o_almostEmpty(ae_o),
    .o_count      (cnt_o),
    .o_maxCount   (max_o),
    .i_clearMax   (clr),
    .o_wpushed    (wpushed),
    .o_rpopped    (rpopped)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: queue of stored words plus a watermark.
  logic [WIDTH-1:0] q[$];
  int mmax = 0;
  int peak = 0;
  int npush = 0;
  bit track = 1'b0;
`ifdef FIFO_SYNC_OUTREG_EN
  bit model_on = 1'b0;
`else
  bit model_on = 1'b1;
`endif

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, then advance the model with the
  // inputs that will be sampled at the coming rising edge.
  initial forever begin
    @(negedge clk);
    if (model_on) begin
      int  sz;
      bit  act, e_push, e_pop;
      sz     = q.size();
      act    = cg && !flush;
      e_push = act && bus.i_wvalid && (sz < DEPTH);
      e_pop  = act && bus.i_rready && (sz > 0);
      chk("count", int'(cnt_o), sz);
      chk("rvalid", int'(bus.o_rvalid), int'(act && sz > 0));
      chk("wready", int'(bus.o_wready), int'(act && sz < DEPTH));
      if (act && sz > 0) chk("rdata", int'(bus.o_rdata), int'(q[0]));
      chk("almostFull", int'(af_o), int'(sz >= int'(af)));
      chk("almostEmpty", int'(ae_o), int'(sz <= int'(ae)));
      chk("maxCount", int'(max_o), mmax);
      chk("wpushed", int'(wpushed), int'(e_push));
      chk("rpopped", int'(rpopped), int'(e_pop));
      if (!rst) begin
        q.delete();
        mmax = 0;
      end else if (cg) begin
        if (flush) begin
          q.delete();
          if (clr) mmax = 0;
        end else begin
          if (e_pop) void'(q.pop_front());
          if (e_push) begin
            q.push_back(bus.i_wdata);
            npush++;
          end
          if (clr) mmax = q.size();
          else if (q.size() > mmax) mmax = q.size();
        end
      end
      if (track && q.size() > peak) peak = q.size();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_wvalid = 1'b0;
    bus.i_rready = 1'b0;
    flush = 1'b0;
    clr = 1'b0;
  endtask

  task automatic push_n(input int n, input logic [WIDTH-1:0] base);
    for (int i = 0; i < n; i++) begin
      bus.i_wvalid = 1'b1;
      bus.i_wdata  = base + WIDTH'(i);
      tick();
    end
    bus.i_wvalid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    bus.i_rready = 1'b1;
    while (cnt_o != '0 && guard < 40) begin
      tick();
      guard++;
    end
    bus.i_rready = 1'b0;
    chk("drain_empty", int'(cnt_o), 0);
  endtask

  initial begin
    rst = 1'b0; cg = 1'b1; af = CNT_W'(4); ae = CNT_W'(1);
    bus.i_wdata = '0;
    idle();
    tick();
    tick();
    rst = 1'b1;
    tick();

    // reset then idle
    probe();
    chk("rst_count", int'(cnt_o), 0);
    chk("rst_rvalid", int'(bus.o_rvalid), 0);
    chk("rst_wready", int'(bus.o_wready), 1);
    chk("rst_ae", int'(ae_o), 1);
    chk("rst_af", int'(af_o), 0);
    tick();

`ifdef FIFO_SYNC_OUTREG_EN
    begin
      int cap;
      push_n(1, 8'hA1);
      probe();
      chk("or_rvalid_n1", int'(bus.o_rvalid), 0);
      tick();
      probe();
      chk("or_rvalid_n2", int'(bus.o_rvalid), 1);
      chk("or_rdata", int'(bus.o_rdata), 8'hA1);
      chk("or_count", int'(cnt_o), 1);
      tick();
      cap = 1;
      bus.i_wvalid = 1'b1;
      for (int i = 0; i < 20; i++) begin
        probe();
        if (wpushed) cap++;
        tick();
      end
      bus.i_wvalid = 1'b0;
      chk("or_capacity", cap, DEPTH + 1);
      chk("or_count_full", int'(cnt_o), DEPTH + 1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      probe();
      chk("or_rst_rvalid", int'(bus.o_rvalid), 0);
      chk("or_rst_count", int'(cnt_o), 0);
    end
`else
    // fill 0x11..0x15, then drain in order
    push_n(5, 8'h11);
    probe();
    chk("full_count", int'(cnt_o), 5);
    chk("full_wready", int'(bus.o_wready), 0);
    chk("full_af", int'(af_o), 1);
    chk("full_max", int'(max_o), 5);
    chk("model_size_full", q.size(), 5);
    tick();
    bus.i_rready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      probe();
      chk("pop_data", int'(bus.o_rdata), 8'h11 + i);
      tick();
    end
    bus.i_rready = 1'b0;
    probe();
    chk("empty_count", int'(cnt_o), 0);
    chk("empty_rvalid", int'(bus.o_rvalid), 0);
    tick();

    // full with simultaneous push and pop: pop only, then both
    push_n(5, 8'h20);
    bus.i_wvalid = 1'b1; bus.i_rready = 1'b1; bus.i_wdata = 8'h30;
    probe();
    chk("fullpp_wpushed", int'(wpushed), 0);
    chk("fullpp_rpopped", int'(rpopped), 1);
    tick();
    probe();
    chk("pp_count", int'(cnt_o), 4);
    chk("pp_wpushed", int'(wpushed), 1);
    chk("pp_rpopped", int'(rpopped), 1);
    tick();
    idle();
    probe();
    chk("pp_count_hold", int'(cnt_o), 4);
    chk("pp_head", int'(bus.o_rdata), 8'h22);
    tick();

    // thresholds above depth and at the edges
    push_n(1, 8'h40);
    af = CNT_W'(6); ae = CNT_W'(5);
    probe();
    chk("af_above_depth", int'(af_o), 0);
    chk("ae_at_depth", int'(ae_o), 1);
    tick();
    af = CNT_W'(0); ae = CNT_W'(0);
    probe();
    chk("af_zero", int'(af_o), 1);
    chk("ae_zero", int'(ae_o), 0);
    tick();
    af = CNT_W'(4); ae = CNT_W'(1);
    drain();

    // flush with push/pop pending, watermark survives, then clear it
    clr = 1'b1;
    tick();
    clr = 1'b0;
    push_n(3, 8'h50);
    flush = 1'b1; bus.i_wvalid = 1'b1; bus.i_rready = 1'b1;
    tick();
    idle();
    probe();
    chk("flush_count", int'(cnt_o), 0);
    chk("flush_rvalid", int'(bus.o_rvalid), 0);
    chk("flush_max", int'(max_o), 3);
    chk("model_max_flush", mmax, 3);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    probe();
    chk("clear_max", int'(max_o), 0);
    tick();

    // random stream
    track = 1'b1;
    for (int c = 0; c < 20000 && npush < 1000; c++) begin
      cg           = ($urandom_range(0, 9) != 0);
      bus.i_wvalid = $urandom_range(0, 2) != 0;
      bus.i_rready = $urandom_range(0, 1) != 0;
      bus.i_wdata  = WIDTH'($urandom);
      if ((c % 16) == 0) begin
        af = CNT_W'($urandom_range(0, 7));
        ae = CNT_W'($urandom_range(0, 7));
      end
      tick();
    end
    cg = 1'b1;
    idle();
    track = 1'b0;
    chk("rand_pushes", (npush >= 1000) ? 1 : 0, 1);
    probe();
    chk("rand_peak", int'(max_o), peak);
    tick();
    af = CNT_W'(4); ae = CNT_W'(1);
    drain();

    // reset mid-stream
    push_n(3, 8'h60);
    probe();
    chk("pre_rst_count", int'(cnt_o), 3);
    tick();
    rst = 1'b0; bus.i_wvalid = 1'b1; bus.i_wdata = 8'h70;
    tick();
    rst = 1'b1;
    idle();
    probe();
    chk("midrst_count", int'(cnt_o), 0);
    chk("midrst_rvalid", int'(bus.o_rvalid), 0);
    chk("midrst_max", int'(max_o), 0);
    tick();
    push_n(1, 8'h77);
    probe();
    chk("post_rst_rvalid", int'(bus.o_rvalid), 1);
    chk("post_rst_data", int'(bus.o_rdata), 8'h77);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
